// File: rtl/instr_assembler_pkg.sv
// -----------------------------------------------------------------------------
// instr_assembler_pkg
// Shared constants for the LEGv8 instruction assembler: instruction length,
// field bit positions (the same positions the decode-side parser extracts),
// format encodings, FSM state encoding and the running-checksum step.
// No ports; imported by instr_pack and instr_assembler.
// -----------------------------------------------------------------------------
package instr_assembler_pkg;

    localparam int INSTR_LEN = 32;

    // Common fields
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 21;
    localparam int RN_MSB    = 9;
    localparam int RN_LSB    = 5;
    localparam int RD_MSB    = 4;
    localparam int RD_LSB    = 0;

    // R-format fields
    localparam int RM_MSB    = 20;
    localparam int RM_LSB    = 16;
    localparam int SHAMT_MSB = 15;
    localparam int SHAMT_LSB = 10;

    // D-format fields
    localparam int DADDR_MSB = 20;
    localparam int DADDR_LSB = 12;
    localparam int OP2_MSB   = 11;
    localparam int OP2_LSB   = 10;

    // Format select encodings
    localparam logic FMT_R = 1'b0;
    localparam logic FMT_D = 1'b1;

    // Load-session FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10
    } asm_state_e;

    // One checksum update: rotate the accumulator left by one, fold in the word.
    function automatic logic [INSTR_LEN-1:0] checksum_step(
        input logic [INSTR_LEN-1:0] acc,
        input logic [INSTR_LEN-1:0] word
    );
        return {acc[INSTR_LEN-2:0], acc[INSTR_LEN-1]} ^ word;
    endfunction

endpackage

// File: rtl/instr_assembler_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational packer: places decoded LEGv8 fields into a 32-bit word.
// Ports:
//   fmt_i      format select (FMT_R / FMT_D)
//   opcode_i   [31:21]
//   rm_i       R: [20:16]        shamt_i  R: [15:10]
//   address_i  D: [20:12]        op2_i    D: [11:10]
//   rn_i       [9:5]             rd_i     [4:0]
//   word_o     packed instruction
// Fields belonging to the unselected format do not reach the output.
// -----------------------------------------------------------------------------
module instr_pack
    import instr_assembler_pkg::*;
(
    input  logic                 fmt_i,
    input  logic [10:0]          opcode_i,
    input  logic [4:0]           rm_i,
    input  logic [5:0]           shamt_i,
    input  logic [8:0]           address_i,
    input  logic [1:0]           op2_i,
    input  logic [4:0]           rn_i,
    input  logic [4:0]           rd_i,
    output logic [INSTR_LEN-1:0] word_o
);

    // Field placement; bits [20:10] are owned by whichever format is selected
    always_comb begin
        word_o                    = {INSTR_LEN{1'b0}};
        word_o[OPC_MSB:OPC_LSB]   = opcode_i;
        if (fmt_i == FMT_D) begin
            word_o[DADDR_MSB:DADDR_LSB] = address_i;
            word_o[OP2_MSB:OP2_LSB]     = op2_i;
        end else begin
            word_o[RM_MSB:RM_LSB]       = rm_i;
            word_o[SHAMT_MSB:SHAMT_LSB] = shamt_i;
        end
        word_o[RN_MSB:RN_LSB]     = rn_i;
        word_o[RD_MSB:RD_LSB]     = rd_i;
    end

endmodule

// File: rtl/instr_assembler.sv
// -----------------------------------------------------------------------------
// instr_assembler
// Streams packed LEGv8 instruction words into instruction memory during a load
// session (IDLE -> LOAD -> DONE). Each accepted field beat becomes one memory
// write one cycle later at the beat's 0-based index within the session.
//
// Parameters: DEPTH (words per session max), ADDR_W (word address width).
// Ports:
//   clk, rst_n                clock, async active-low reset
//   start                     opens a session (ignored while loading)
//   in_valid / in_ready       beat handshake; in_ready decodes state only
//   in_fmt, in_opcode, in_rm, in_shamt, in_address, in_op2, in_rn, in_rd
//                             decoded fields of one instruction
//   in_last                   beat closes the session
//   imem_we/imem_addr/imem_wdata  registered memory write port
//   busy, done                session status
//   count                     words written this (or the last) session
//   overflow                  session closed by DEPTH without in_last
//   checksum                  rotate-xor of written words
// Optional build macro INSTR_ASM_CHECKSUM_EN: adds the checksum port and its
// register; without it the rest of the behaviour is unchanged.
// -----------------------------------------------------------------------------
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_fmt,
    input  logic [10:0]          in_opcode,
    input  logic [4:0]           in_rm,
    input  logic [5:0]           in_shamt,
    input  logic [8:0]           in_address,
    input  logic [1:0]           in_op2,
    input  logic [4:0]           in_rn,
    input  logic [4:0]           in_rd,
    input  logic                 in_last,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [INSTR_LEN-1:0] imem_wdata,
    output logic                 busy,
    output logic                 done,
`ifdef INSTR_ASM_CHECKSUM_EN
    output logic [INSTR_LEN-1:0] checksum,
`endif
    output logic [ADDR_W:0]      count,
    output logic                 overflow
);

    // Index of the final slot; a beat accepted here always closes the session
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    asm_state_e            state_q, state_d;
    logic [ADDR_W:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [INSTR_LEN-1:0]  wdata_q, wdata_d;
    logic [INSTR_LEN-1:0]  packed_s;
    logic                  accept_s;
    logic                  at_last_idx_s;
    logic                  close_s;
    logic                  enter_load_s;
`ifdef INSTR_ASM_CHECKSUM_EN
    logic [INSTR_LEN-1:0]  checksum_q, checksum_d;
`endif

    instr_pack u_pack (
        .fmt_i     (in_fmt),
        .opcode_i  (in_opcode),
        .rm_i      (in_rm),
        .shamt_i   (in_shamt),
        .address_i (in_address),
        .op2_i     (in_op2),
        .rn_i      (in_rn),
        .rd_i      (in_rd),
        .word_o    (packed_s)
    );

    assign in_ready      = (state_q == ST_LOAD);
    assign accept_s      = in_valid & in_ready;
    assign at_last_idx_s = (count_q == LAST_IDX);
    assign close_s       = accept_s & (in_last | at_last_idx_s);

    // Next-state logic; start only opens a session from IDLE or DONE
    always_comb begin
        state_d      = state_q;
        enter_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    enter_load_s = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (close_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    enter_load_s = 1'b1;
                end else begin
                    state_d      = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-port and session-counter next values; accept and enter_load never coincide
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef INSTR_ASM_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        if (enter_load_s) begin
            count_d    = {(ADDR_W+1){1'b0}};
            overflow_d = 1'b0;
`ifdef INSTR_ASM_CHECKSUM_EN
            checksum_d = {INSTR_LEN{1'b0}};
`endif
        end else if (accept_s) begin
            we_d       = 1'b1;
            addr_d     = count_q[ADDR_W-1:0];
            wdata_d    = packed_s;
            count_d    = count_q + (ADDR_W+1)'(1);
            overflow_d = at_last_idx_s & ~in_last;
`ifdef INSTR_ASM_CHECKSUM_EN
            checksum_d = checksum_step(checksum_q, packed_s);
`endif
        end else begin
            we_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= {(ADDR_W+1){1'b0}};
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {INSTR_LEN{1'b0}};
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef INSTR_ASM_CHECKSUM_EN
    // Running checksum register, updated alongside the write it covers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= {INSTR_LEN{1'b0}};
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == ST_LOAD);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_assembler.sv
// -----------------------------------------------------------------------------
// tb_instr_assembler
// Self-checking bench for instr_assembler (DEPTH=4, ADDR_W=3). A behavioural
// session model (index counter, overflow rule, rotate-xor checksum, arithmetic
// field packing) predicts every write and status value.
// -----------------------------------------------------------------------------
module tb_instr_assembler;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_fmt = 1'b0;
    logic [10:0]       in_opcode = 11'd0;
    logic [4:0]        in_rm = 5'd0;
    logic [5:0]        in_shamt = 6'd0;
    logic [8:0]        in_address = 9'd0;
    logic [1:0]        in_op2 = 2'd0;
    logic [4:0]        in_rn = 5'd0;
    logic [4:0]        in_rd = 5'd0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              overflow;
`ifdef INSTR_ASM_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    instr_assembler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fmt     (in_fmt),
        .in_opcode  (in_opcode),
        .in_rm      (in_rm),
        .in_shamt   (in_shamt),
        .in_address (in_address),
        .in_op2     (in_op2),
        .in_rn      (in_rn),
        .in_rd      (in_rd),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
`ifdef INSTR_ASM_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural session model
    bit          m_load = 1'b0;
    bit          m_done = 1'b0;
    int          m_count = 0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_cks = 32'd0;

    function automatic logic [31:0] ref_word(input bit fmt, input int op, input int rm,
                                             input int sh, input int ad, input int op2,
                                             input int rn, input int rd);
        longint w;
        if (fmt)
            w = longint'(op) * 2097152 + longint'(ad) * 4096 + longint'(op2) * 1024
                + longint'(rn) * 32 + longint'(rd);
        else
            w = longint'(op) * 2097152 + longint'(rm) * 65536 + longint'(sh) * 1024
                + longint'(rn) * 32 + longint'(rd);
        return w[31:0];
    endfunction

    task automatic model_reset();
        m_load = 1'b0; m_done = 1'b0; m_count = 0; m_ovf = 1'b0; m_cks = 32'd0;
    endtask

    task automatic model_start();
        if (!m_load) begin
            m_load = 1'b1; m_done = 1'b0; m_count = 0; m_ovf = 1'b0; m_cks = 32'd0;
        end
    endtask

    task automatic rand_fields();
        in_fmt     = 1'($urandom_range(0, 1));
        in_opcode  = 11'($urandom);
        in_rm      = 5'($urandom);
        in_shamt   = 6'($urandom);
        in_address = 9'($urandom);
        in_op2     = 2'($urandom);
        in_rn      = 5'($urandom);
        in_rd      = 5'($urandom);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_start();
        checks++;
        if (busy !== m_load || done !== m_done || count !== (ADDR_W+1)'(m_count) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL start: busy=%0b done=%0b count=%0d ovf=%0b exp %0b %0b %0d %0b",
                     busy, done, count, overflow, m_load, m_done, m_count, m_ovf);
        end
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (imem_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_we: imem_we=%0b exp 0", imem_we);
        end
    endtask

    // Presents the current fields for one cycle and checks the resulting write
    task automatic send_beat(input bit last);
        bit          acc;
        int          idx;
        logic [31:0] exp;
        in_last  = last;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== m_load) begin
            errors++;
            $display("FAIL ready: in_ready=%0b exp %0b", in_ready, m_load);
        end
        acc = m_load;
        exp = ref_word(in_fmt, int'(in_opcode), int'(in_rm), int'(in_shamt), int'(in_address),
                       int'(in_op2), int'(in_rn), int'(in_rd));
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (acc) begin
            idx = m_count;
            m_count++;
            m_cks = {m_cks[30:0], m_cks[31]} ^ exp;
            if (m_count == DEPTH && !last) m_ovf = 1'b1;
            if (last || m_count == DEPTH) begin
                m_load = 1'b0; m_done = 1'b1;
            end
            checks++;
            if (imem_we !== 1'b1 || imem_addr !== ADDR_W'(idx) || imem_wdata !== exp) begin
                errors++;
                $display("FAIL write: we=%0b addr=%0d data=%h exp 1 %0d %h",
                         imem_we, imem_addr, imem_wdata, idx, exp);
            end
            checks++;
            if (count !== (ADDR_W+1)'(m_count) || done !== m_done || overflow !== m_ovf
                || in_ready !== m_load || busy !== m_load) begin
                errors++;
                $display("FAIL status: count=%0d done=%0b ovf=%0b rdy=%0b busy=%0b exp %0d %0b %0b %0b",
                         count, done, overflow, in_ready, busy, m_count, m_done, m_ovf, m_load);
            end
`ifdef INSTR_ASM_CHECKSUM_EN
            checks++;
            if (checksum !== m_cks) begin
                errors++;
                $display("FAIL checksum_step: checksum=%h exp %h", checksum, m_cks);
            end
`endif
        end else begin
            checks++;
            if (imem_we !== 1'b0 || count !== (ADDR_W+1)'(m_count)) begin
                errors++;
                $display("FAIL no_write: we=%0b count=%0d exp 0 %0d", imem_we, count, m_count);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0 || count !== '0
            || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: we=%0b addr=%0d data=%h count=%0d ovf=%0b busy=%0b done=%0b rdy=%0b exp all 0",
                     tag, imem_we, imem_addr, imem_wdata, count, overflow, busy, done, in_ready);
        end
`ifdef INSTR_ASM_CHECKSUM_EN
        checks++;
        if (checksum !== 32'd0) begin
            errors++;
            $display("FAIL %s_checksum: checksum=%h exp 0", tag, checksum);
        end
`endif
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #11;
        check_reset_outputs("reset");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_start_with_beat_idle();
        rand_fields();
        in_last  = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        model_start();
        checks++;
        if (imem_we !== 1'b0 || count !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_beat_idle: we=%0b count=%0d busy=%0b exp 0 0 1", imem_we, count, busy);
        end
        rand_fields();
        send_beat(1'b1);
    endtask

    task automatic test_r_add();
        start_pulse();
        in_fmt = 1'b0; in_opcode = 11'h458; in_rm = 5'd2; in_shamt = 6'd0;
        in_address = 9'h1FF; in_op2 = 2'd3; in_rn = 5'd1; in_rd = 5'd3;
        send_beat(1'b1);
        checks++;
        if (imem_wdata !== 32'h8B020023 || imem_addr !== '0 || done !== 1'b1 || count !== 4'd1) begin
            errors++;
            $display("FAIL r_add: data=%h addr=%0d done=%0b count=%0d exp 8b020023 0 1 1",
                     imem_wdata, imem_addr, done, count);
        end
        idle_cycle();
    endtask

    task automatic test_d_ldur();
        start_pulse();
        in_fmt = 1'b1; in_opcode = 11'h7C2; in_rm = 5'h1F; in_shamt = 6'h3F;
        in_address = 9'd8; in_op2 = 2'd0; in_rn = 5'd4; in_rd = 5'd5;
        send_beat(1'b1);
        checks++;
        if (imem_wdata !== 32'hF8408085) begin
            errors++;
            $display("FAIL d_ldur: data=%h exp f8408085", imem_wdata);
        end
    endtask

    task automatic test_gapped();
        start_pulse();
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            send_beat(i == 2);
            if (i < 2) idle_cycle();
        end
        checks++;
        if (count !== 4'd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL gapped: count=%0d done=%0b exp 3 1", count, done);
        end
        idle_cycle();
    endtask

    task automatic test_overflow();
        start_pulse();
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            send_beat(1'b0);
        end
        checks++;
        if (overflow !== 1'b1 || count !== 4'd4 || in_ready !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL overflow: ovf=%0b count=%0d rdy=%0b done=%0b exp 1 4 0 1",
                     overflow, count, in_ready, done);
        end
    endtask

    task automatic test_full_with_last();
        start_pulse();
        for (int i = 0; i < DEPTH; i++) begin
            rand_fields();
            send_beat(i == DEPTH - 1);
        end
        checks++;
        if (overflow !== 1'b0 || count !== 4'd4) begin
            errors++;
            $display("FAIL full_last: ovf=%0b count=%0d exp 0 4", overflow, count);
        end
    endtask

    task automatic test_start_in_load();
        start_pulse();
        rand_fields();
        send_beat(1'b0);
        start_pulse();
        rand_fields();
        send_beat(1'b1);
    endtask

    task automatic test_random_sessions();
        int n;
        bit last;
        for (int s = 0; s < 8; s++) begin
            start_pulse();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                rand_fields();
                if (i == n - 1) last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
                else last = 1'b0;
                send_beat(last);
                if ($urandom_range(0, 1) == 1) idle_cycle();
            end
        end
    endtask

    task automatic test_reset_mid();
        start_pulse();
        for (int i = 0; i < 2; i++) begin
            rand_fields();
            send_beat(1'b0);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        model_reset();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        start_pulse();
        rand_fields();
        send_beat(1'b1);
        checks++;
        if (imem_addr !== '0 || count !== 4'd1) begin
            errors++;
            $display("FAIL reset_restart: addr=%0d count=%0d exp 0 1", imem_addr, count);
        end
    endtask

`ifdef INSTR_ASM_CHECKSUM_EN
    task automatic test_checksum();
        start_pulse();
        in_fmt = 1'b0; in_opcode = 11'h000; in_rm = 5'd0; in_shamt = 6'd0;
        in_rn = 5'd0; in_rd = 5'd1;
        send_beat(1'b0);
        in_opcode = 11'h400; in_rd = 5'd0;
        send_beat(1'b1);
        checks++;
        if (checksum !== 32'h80000002 || done !== 1'b1) begin
            errors++;
            $display("FAIL checksum: checksum=%h done=%0b exp 80000002 1", checksum, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start_with_beat_idle();
        test_r_add();
        test_d_ldur();
        test_gapped();
        test_overflow();
        test_full_with_last();
        test_start_in_load();
        test_random_sessions();
        test_reset_mid();
`ifdef INSTR_ASM_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
